// File: rtl/shift_iter_if.sv
// Operand/result bundle between decode/writeback and the iterative shift unit.
// Suffixes are relative to the shift unit: _i flows into it, _o flows out of it.
interface shift_iter_if;
  logic        start_i;
  logic [15:0] in_i;
  logic [1:0]  op_i;
  logic [3:0]  cnt_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] out_o;

  modport master (output start_i, in_i, op_i, cnt_i, input  busy_o, done_o, out_o);
  modport slave  (input  start_i, in_i, op_i, cnt_i, output busy_o, done_o, out_o);
endinterface

// File: rtl/shift_iter.sv
// Iterative 16-bit shifter: one position per cycle through shifter_1.
// Define SHIFT_ITER_DOUBLE_EN to chain a second stage (two positions per cycle).

module shifter_1 (
  input  logic [15:0] d_i,
  input  logic [1:0]  op_i,
  input  logic        sh_i,
  output logic [15:0] q_o
);
  always_comb begin
    q_o = d_i;
    if (sh_i) begin
      case (op_i)
        2'b00:   q_o = {d_i[14:0], d_i[15]};
        2'b01:   q_o = {d_i[14:0], 1'b0};
        2'b10:   q_o = {d_i[15], d_i[15:1]};
        default: q_o = {1'b0, d_i[15:1]};
      endcase
    end
  end
endmodule

module shift_iter (
  input  logic        clk,
  input  logic        rst_n,
  shift_iter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  opr_q, opr_d;
  logic [3:0]  rem_q, rem_d;
  logic [15:0] s1, shift_res;
  logic [3:0]  step;

  shifter_1 u_stage0 (.d_i(data_q), .op_i(opr_q), .sh_i(1'b1), .q_o(s1));

`ifdef SHIFT_ITER_DOUBLE_EN
  logic [15:0] s2;
  logic        sh2;
  // Second stage idles on the odd final position so the result matches the single build.
  assign sh2 = (rem_q >= 4'd2);
  shifter_1 u_stage1 (.d_i(s1), .op_i(opr_q), .sh_i(sh2), .q_o(s2));
  assign shift_res = s2;
  assign step      = sh2 ? 4'd2 : 4'd1;
`else
  assign shift_res = s1;
  assign step      = 4'd1;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    opr_d   = opr_q;
    rem_d   = rem_q;
    case (state_q)
      SHIFT: begin
        data_d  = shift_res;
        rem_d   = rem_q - step;
        state_d = (rem_q == step) ? DONE : SHIFT;
      end
      default: begin
        // IDLE and DONE both accept, giving back-to-back issue off the done cycle.
        if (bus.start_i) begin
          data_d  = bus.in_i;
          opr_d   = bus.op_i;
          rem_d   = bus.cnt_i;
          state_d = (bus.cnt_i == 4'd0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      opr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      opr_q   <= opr_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy_o = (state_q == SHIFT);
  assign bus.done_o = (state_q == DONE);
  assign bus.out_o  = data_q;
endmodule
